robs_control: RTL and testbench

- Moore FSM sequencer for the signed Robertson multiplier datapath.
- Accepts a start request and drives the 15-bit control word `c[14:0]` each cycle.
- Consumes the datapath status flags `zr` (R LSB clear) and `zq` (down-counter at a multiple of 8).
- Signals completion with a one-cycle `done`; the product is valid on the datapath product bus from `done` onward.

---
 rtl/robs_pkg.sv | 96 +++++++++
 rtl/robs_control.sv | 97 +++++++++
 tb/tb_robs_control.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/robs_pkg.sv
// Shared definitions for the Robertson multiplier sequencer and its datapath:
// state encoding, control-word bit positions, select encodings and the decoder.
package robs_pkg;

  localparam int CW = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LOADR,
    S_TEST,
    S_ADD,
    S_SUB,
    S_SHIFT,
    S_WRITE,
    S_STORE,
    S_DONE
  } state_t;

  localparam int C_LDY   = 0;
  localparam int C_CRST  = 1;
  localparam int C_CLRA  = 2;
  localparam int C_LDX   = 3;
  localparam int C_RHSEL = 4;   // two bits: 5:4
  localparam int C_RLSEL = 6;
  localparam int C_XSEL  = 7;
  localparam int C_LDRH  = 8;
  localparam int C_LDRL  = 9;
  localparam int C_ALU   = 10;
  localparam int C_SHA   = 11;
  localparam int C_SHE   = 12;
  localparam int C_DEC   = 13;
  localparam int C_LDA   = 14;

  localparam logic [1:0] RH_A     = 2'd0;
  localparam logic [1:0] RH_SHIFT = 2'd1;
  localparam logic [1:0] RH_ALU   = 2'd2;

  localparam logic RL_X     = 1'b0;
  localparam logic RL_SHIFT = 1'b1;

  localparam logic X_MULT = 1'b0;
  localparam logic X_RLOW = 1'b1;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  function automatic logic [CW-1:0] decode(input state_t s);
    logic [CW-1:0] w;
    w = '0;
    case (s)
      S_INIT: begin
        w[C_LDY]  = 1'b1;
        w[C_CRST] = 1'b1;
        w[C_CLRA] = 1'b1;
        w[C_LDX]  = 1'b1;
        w[C_XSEL] = X_MULT;
      end
      S_LOADR: begin
        w[C_LDRH]        = 1'b1;
        w[C_LDRL]        = 1'b1;
        w[C_RHSEL +: 2]  = RH_A;
        w[C_RLSEL]       = RL_X;
      end
      S_ADD: begin
        w[C_LDRH]       = 1'b1;
        w[C_RHSEL +: 2] = RH_ALU;
        w[C_ALU]        = ALU_ADD;
      end
      S_SUB: begin
        w[C_LDRH]       = 1'b1;
        w[C_RHSEL +: 2] = RH_ALU;
        w[C_ALU]        = ALU_SUB;
      end
      S_SHIFT: begin
        w[C_SHA] = 1'b1;
        w[C_SHE] = 1'b1;
      end
      S_WRITE: begin
        w[C_LDRH]       = 1'b1;
        w[C_LDRL]       = 1'b1;
        w[C_DEC]        = 1'b1;
        w[C_RHSEL +: 2] = RH_SHIFT;
        w[C_RLSEL]      = RL_SHIFT;
      end
      S_STORE: begin
        w[C_LDA]  = 1'b1;
        w[C_LDX]  = 1'b1;
        w[C_XSEL] = X_RLOW;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/robs_control.sv
// Moore sequencer for the signed Robertson multiplier: walks the multiplier
// bits LSB first, adding (or subtracting on the sign bit) and shifting.
//
// state  | meaning
// IDLE   | waiting for start, control word idle
// INIT   | load Y and X, clear A, reset datapath down-counter
// LOADR  | R <= {A, X}
// TEST   | branch on current multiplier bit
// ADD    | RH <= RH + Y
// SUB    | RH <= RH - Y (sign bit of multiplier only)
// SHIFT  | arithmetic right shift of R into shifter
// WRITE  | R <= shifted, counter decrement, iteration check
// STORE  | A <= RH, X <= R low (product = {A, X})
// DONE   | one-cycle completion pulse
module robs_control
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          zr,
  input  logic          zq,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] iter, iter_nxt;
  logic          err_nxt;
  logic          last;

  assign last = (iter == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      iter  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    err_nxt   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_INIT;
          err_nxt   = 1'b0;
        end
      end
      S_INIT: begin
        iter_nxt  = '0;
        state_nxt = S_LOADR;
      end
      S_LOADR: state_nxt = S_TEST;
      S_TEST: begin
        if (zr)        state_nxt = S_SHIFT;
        else if (last) state_nxt = S_SUB;
        else           state_nxt = S_ADD;
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SUB:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_WRITE;
      S_WRITE: begin
        // zq is only a consistency check; iter alone decides termination
        if (zq != last) err_nxt = 1'b1;
        if (last) begin
          state_nxt = S_STORE;
        end else begin
          iter_nxt  = iter + 1'b1;
          state_nxt = S_TEST;
        end
      end
      S_STORE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign c    = decode(state);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_robs_control.sv
// Directed bench: pairs the sequencer with a behavioural Robertson datapath
// and checks products, completion edge, control-word properties and err.
module tb_robs_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        zr, zq;
  logic [14:0] c;
  logic        busy, done, err;

  always #5 clk = ~clk;

  robs_control #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .zr    (zr),
    .zq    (zq),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // behavioural datapath
  logic [7:0]  mcand = 8'd0, mplier = 8'd0;
  logic [7:0]  y, a, xr, rl;
  logic [8:0]  rh, alu;
  logic [16:0] sh;
  logic [2:0]  cnt;
  logic        zq_force = 1'b0;

  assign alu = c[10] ? (rh + {y[7], y}) : (rh - {y[7], y});
  assign zr  = ~rl[0];
  assign zq  = zq_force | (cnt == 3'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0; a <= '0; xr <= '0; rl <= '0; rh <= '0; sh <= '0; cnt <= '0;
    end else begin
      if (c[0]) y <= mcand;
      if (c[1]) cnt <= 3'd7;
      else if (c[13]) cnt <= cnt - 3'd1;
      if (c[2]) a <= 8'd0;
      else if (c[14]) a <= rh[7:0];
      if (c[3]) xr <= c[7] ? rl : mplier;
      if (c[8]) begin
        case (c[5:4])
          2'd0:    rh <= {a[7], a};
          2'd1:    rh <= sh[16:8];
          default: rh <= alu;
        endcase
      end
      if (c[9]) rl <= c[6] ? sh[7:0] : xr;
      if (c[12]) sh <= c[11] ? {rh[8], rh, rl[7:1]} : {1'b0, rh, rl[7:1]};
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int   edges, n_alu, n_sub, last_alu_sub;
  int   prod;
  logic err1, err6, err7, err_done, done_after, busy_after;

  // Edge 1 is the edge that samples start; edges = edge after which done is high.
  task automatic run(input logic [7:0] mc, input logic [7:0] mp, input int pulse_at);
    mcand = mc;
    mplier = mp;
    n_alu = 0; n_sub = 0; last_alu_sub = 0;
    err1 = 1'bx; err6 = 1'bx; err7 = 1'bx;
    edges = 0;
    @(negedge clk);
    start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) start = 1'b0;
      if (pulse_at > 1 && edges == pulse_at) start = 1'b1;
      else if (pulse_at > 1 && edges == pulse_at + 1) start = 1'b0;
      if (c[5:4] == 2'd2) begin
        n_alu++;
        last_alu_sub = c[10] ? 0 : 1;
        if (!c[10]) n_sub++;
      end
      if (edges == 1) err1 = err;
      if (edges == 6) err6 = err;
      if (edges == 7) err7 = err;
    end while (!done && edges < 60);
    prod = int'({a, xr});
    err_done = err;
    start = 1'b0;
    @(posedge clk);
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  initial begin
    #12;
    chk("reset_c", int'(c), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'd5, 8'd3, 0);
    chk("5x3_edge", edges, 30);
    chk("5x3_prod", prod, 16'h000F);
    chk("5x3_err", int'(err_done), 0);
    chk("5x3_adds", n_alu, 2);
    chk("5x3_done_pulse", int'(done_after), 0);
    chk("5x3_idle", int'(busy_after), 0);

    run(8'h80, 8'h80, 0);
    chk("m128sq_edge", edges, 29);
    chk("m128sq_prod", prod, 16'h4000);
    chk("m128sq_subs", n_sub, 1);

    run(8'h7F, 8'hFF, 0);
    chk("7Fxff_edge", edges, 36);
    chk("7Fxff_prod", prod, 16'hFF81);
    chk("7Fxff_alus", n_alu, 8);
    chk("7Fxff_subs", n_sub, 1);
    chk("7Fxff_last_sub", last_alu_sub, 1);

    run(8'h5A, 8'h00, 0);
    chk("x0_edge", edges, 28);
    chk("x0_prod", prod, 0);
    chk("x0_no_alu", n_alu, 0);

    // asynchronous reset mid-operation
    mcand = 8'd5;
    mplier = 8'd3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_c", int'(c), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk);
    #1;
    chk("abort_c_held", int'(c), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'd5, 8'd3, 0);
    chk("after_abort_edge", edges, 30);
    chk("after_abort_prod", prod, 16'h000F);

    // zq stuck at 1, plus a start pulse while busy
    zq_force = 1'b1;
    run(8'd5, 8'd3, 12);
    chk("zq_err_before_write", int'(err6), 0);
    chk("zq_err_after_write", int'(err7), 1);
    chk("zq_edge", edges, 30);
    chk("zq_prod", prod, 16'h000F);
    chk("zq_err_sticky", int'(err_done), 1);
    chk("zq_err_idle", int'(err), 1);
    zq_force = 1'b0;
    run(8'd5, 8'd3, 0);
    chk("err_cleared_on_start", int'(err1), 0);
    chk("err_clean_run", int'(err_done), 0);

    // start held high relaunches after DONE
    @(negedge clk);
    start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 60);
    chk("hold_done_seen", int'(done), 1);
    @(posedge clk);
    #1;
    chk("hold_idle", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("hold_relaunch_busy", int'(busy), 1);
    chk("hold_relaunch_init", int'(c), 16'h000F);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
